sort_drain: RTL
===============

# sort_drain

Output-side companion of the systolic sorter: captures one sorted burst (the sorter's `q`/`active_output` stream, one word per cycle with no backpressure) into a local SIZE-entry buffer and replays it to a downstream consumer over a valid/ready interface with backpressure and an end-of-frame marker. It sits between the sorter and any stalling sink (FIFO, bus master, UART framer), so the sorter never has to stall mid-burst.

## Interface
- `SIZE`, 8: buffer depth in words; equals the sorter's frame size.
- `WIDTH`, 32: data word width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `d`  in  WIDTH  sorted word from sorter.
- `d_valid`  in  1  `d` valid this cycle; one burst is a contiguous run of high cycles.
- `busy`  out  1  high while a frame is being captured or drained; upstream must not start a new burst while high.
- `q`  out  WIDTH  output word.
- `q_valid`  out  1  `q` valid.
- `q_ready`  in  1  consumer accepts `q` when `q_valid && q_ready`.
- `q_last`  out  1  marks final word of the frame; qualified by `q_valid`.
- `overflow`  out  1  sticky: a word was dropped.
- `order_err`  out  1  sticky: captured frame not non-decreasing (see Configuration).

## Operation
- States: IDLE, CAPTURE, DRAIN. Write count `wcnt`, read index `rcnt`, frame length `len` (each clogb2(SIZE)+1 bits wide).
- IDLE: `busy`=0. When `d_valid`=1: write `d` to mem[0], `wcnt`<=1, go to CAPTURE.
- CAPTURE: `busy`=1.
  - `d_valid`=1 and `wcnt`<SIZE: write mem[`wcnt`], increment `wcnt`.
  - `d_valid`=1 and `wcnt`==SIZE: word dropped, `overflow`<=1, stay.
  - `d_valid`=0: `len`<=`wcnt`, `q`<=mem[0], `q_valid`<=1, `q_last`<=(`wcnt`==1), `rcnt`<=0, go to DRAIN.
- DRAIN: `busy`=1. On handshake:
  - `rcnt`==`len`-1: `q_valid`<=0, `q_last`<=0, `q`<=0, go to IDLE.
  - Otherwise: `q`<=mem[`rcnt`+1], `q_last`<=(`rcnt`+2==`len`), increment `rcnt`.
  - Without a handshake, `q`, `q_valid` and `q_last` hold.
- `d_valid`=1 in DRAIN: word dropped, `overflow`<=1; buffer and state are not affected.
- Short bursts (1..SIZE-1 words) are legal. `len` is the captured count, and `q_last` lands on the final captured word.
- `overflow` and `order_err` clear only on `rst`.

## Timing
- Reset values: `q`=0, `q_valid`=0, `q_last`=0, `busy`=0, `overflow`=0, `order_err`=0, state IDLE, counters 0. Buffer contents are don't-care.
- `busy` rises the cycle after the first `d_valid` edge is sampled.
- Capture-to-output latency: last word sampled at edge t. Edge t+1 samples `d_valid`=0. `q_valid`=1 with mem[0] from after edge t+1.
- Throughput with `q_ready` held high: one word per cycle, so SIZE words occupy SIZE consecutive cycles.
- After the final handshake at edge u, `busy`=0 from u. A new burst can be sampled at edge u+1.
- Reset mid-capture or mid-drain: the frame is discarded and all outputs return to reset values on the next edge. No partial `q_last` is emitted.
- `q_valid` never drops without a handshake (AXI-stream rule). `q` and `q_last` are stable while `q_valid && !q_ready`.

## Configuration
- `SORT_DRAIN_ORDER_CHECK_EN` defined: in CAPTURE, each written word (second onward) is compared unsigned against the previous written word. If it is less, `order_err`<=1. The previous word is held in a WIDTH-bit register. Dropped words are not checked.
- Not defined: no comparator or register is built, and `order_err` is tied to 0.

## Test plan
- SIZE=8, burst 1,2,…,8 on consecutive cycles, `q_ready`=1:
  - `q_valid` one cycle after `d_valid` falls.
  - `q` = 1..8 on 8 consecutive cycles, `q_last` only with 8.
  - `busy` falls after the 8th handshake.
- Same burst with `q_ready` toggling 1,0,0,1,…:
  - every word is delivered exactly once, in order.
  - `q` is stable across stalls, and no word is lost or duplicated.
- Burst of 3 words (5,9,9): `len`=3, output is 5,9,9, and `q_last` is on the third word. `order_err`=0.
- Burst of 10 words (1..10): outputs 1..8, `overflow`=1. Then a second burst of 4 words while draining with `q_ready`=0: those 4 words are dropped, `overflow` stays 1, and the drain completes unchanged.
- Burst 4,3,… with macro defined: `order_err`=1 after the second word. With the macro undefined: `order_err`=0.
- Assert `rst` during the 4th output word: the next cycle `q_valid`=0, `q`=0, `busy`=0. A fresh 8-word burst then drains correctly.

Source files
------------

// File: rtl/sort_drain.sv
// Captures one sorted burst into a local buffer and replays it over valid/ready with a last marker.
// Optional SORT_DRAIN_ORDER_CHECK_EN builds a non-decreasing order checker on captured words.
module sort_drain #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_last,
  output logic             overflow,
  output logic             order_err
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              wcnt_q, wcnt_d;
  logic [CW-1:0]              rcnt_q, rcnt_d;
  logic [CW-1:0]              len_q, len_d;
  logic [WIDTH-1:0]           q_data_q, q_data_d;
  logic                       q_valid_q, q_valid_d;
  logic                       q_last_q, q_last_d;
  logic                       overflow_q, overflow_d;
  logic [SIZE-1:0][WIDTH-1:0] mem_q;
  logic                       mem_we;
  logic [AW-1:0]              mem_waddr;
  logic [AW-1:0]              ridx;

  assign ridx = rcnt_q[AW-1:0] + AW'(1);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    len_d      = len_q;
    q_data_d   = q_data_q;
    q_valid_d  = q_valid_q;
    q_last_d   = q_last_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    case (state_q)
      S_IDLE: begin
        if (d_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wcnt_d    = CW'(1);
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (d_valid) begin
          if (wcnt_q < CW'(SIZE)) begin
            mem_we    = 1'b1;
            mem_waddr = wcnt_q[AW-1:0];
            wcnt_d    = wcnt_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          // Burst ended: present the first word right away so the drain runs at full rate.
          len_d     = wcnt_q;
          q_data_d  = mem_q[0];
          q_valid_d = 1'b1;
          q_last_d  = (wcnt_q == CW'(1));
          rcnt_d    = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (d_valid) overflow_d = 1'b1;
        if (q_valid_q && q_ready) begin
          if (rcnt_q == len_q - CW'(1)) begin
            q_valid_d = 1'b0;
            q_last_d  = 1'b0;
            q_data_d  = '0;
            state_d   = S_IDLE;
          end else begin
            q_data_d = mem_q[ridx];
            q_last_d = ((rcnt_q + CW'(2)) == len_q);
            rcnt_d   = rcnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      len_q      <= '0;
      q_data_q   <= '0;
      q_valid_q  <= 1'b0;
      q_last_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      len_q      <= len_d;
      q_data_q   <= q_data_d;
      q_valid_q  <= q_valid_d;
      q_last_q   <= q_last_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= d;
  end

`ifdef SORT_DRAIN_ORDER_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             order_err_q, order_err_d;

  always_comb begin
    prev_d      = prev_q;
    order_err_d = order_err_q;
    if (mem_we) begin
      prev_d = d;
      if ((state_q == S_CAPTURE) && (d < prev_q)) order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign q        = q_data_q;
  assign q_valid  = q_valid_q;
  assign q_last   = q_last_q;
  assign overflow = overflow_q;

endmodule
